dds_nco: RTL and testbench

- Numerically controlled oscillator feeding the waveform ROM and the DAC/PWM output stages.
- Owns the phase accumulator, quarter-wave ROM address folding and sample reconstruction.
- Emits one offset-binary DATA_W-bit sample per sample-rate tick, plus a 1-cycle valid strobe for spi2dac/pwm loading.
- Modes: sine (via external quarter-wave ROM), sawtooth, square, triangle.

---
 rtl/dds_pkg.sv | 12 +
 rtl/dds_nco_if.sv | 24 ++
 rtl/nco_shaper.sv | 20 ++
 rtl/dds_nco.sv | 78 +++++++
 tb/tb_dds_nco.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared mode encodings and constants for the NCO and its bench
package dds_pkg;
  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_TRI    = 2'd3
  } mode_e;
  localparam int NCO_LAT    = 3;
  localparam int DATA_W_DEF = 10;
  localparam int MIDSCALE   = 2 ** (DATA_W_DEF - 1);
endpackage

// File: rtl/dds_nco_if.sv
// dds_nco_if: tick/control inputs, ROM port and sample outputs of the NCO
interface dds_nco_if #(
  parameter int ACC_W   = 16,
  parameter int QADDR_W = 8,
  parameter int DATA_W  = 10
);
  import dds_pkg::*;
  logic               tick;
  logic [ACC_W-1:0]   freq_word;
  logic [ACC_W-1:0]   phase_offset;
  mode_e              mode;
  logic [QADDR_W-1:0] rom_addr;
  logic [DATA_W-2:0]  rom_data;
  logic [DATA_W-1:0]  sample_out;
  logic               sample_valid;
  modport slave (
    input  tick, freq_word, phase_offset, mode, rom_data,
    output rom_addr, sample_out, sample_valid
  );
  modport master (
    output tick, freq_word, phase_offset, mode, rom_data,
    input  rom_addr, sample_out, sample_valid
  );
endinterface

// File: rtl/nco_shaper.sv
// nco_shaper: combinational waveform reconstruction from phase and quarter-wave ROM data
module nco_shaper
  import dds_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int DATA_W = 10
) (
  input  mode_e             mode,
  input  logic              neg,
  input  logic [ACC_W-1:0]  ph,
  input  logic [DATA_W-2:0] rom_data,
  output logic [DATA_W-1:0] sample
);
  // negative half: midscale-1-rom_data is just the bitwise complement with a 0 MSB
  always_comb
    sample = mode == MODE_SINE   ? (neg ? {1'b0, ~rom_data} : {1'b1, rom_data}) :
             mode == MODE_SAW    ? ph[ACC_W-1 -: DATA_W] :
             mode == MODE_SQUARE ? {DATA_W{~ph[ACC_W-1]}} :
                                   ph[ACC_W-2 -: DATA_W] ^ {DATA_W{ph[ACC_W-1]}};
endmodule

// File: rtl/dds_nco.sv
// dds_nco: phase accumulator, quarter-wave folding and 3-cycle sample pipeline
module dds_nco
  import dds_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int QADDR_W = 8,
  parameter int DATA_W  = 10
) (
  input logic      CLOCK_50,
  input logic      rst_n,
  dds_nco_if.slave bus
);
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  logic [ACC_W-1:0]   acc_q, acc_d, ph1_q, ph1_d, ph2_q, ph2_d, ph3_q, ph3_d;
  mode_e              mode1_q, mode1_d, mode2_q, mode2_d, mode3_q, mode3_d;
  logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic               neg2_q, neg2_d, neg3_q, neg3_d;
  logic [QADDR_W-1:0] idx, rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]  shaped, sample_q, sample_d;
  logic               valid_q, valid_d;
  nco_shaper #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_shaper (
    .mode     (mode3_q),
    .neg      (neg3_q),
    .ph       (ph3_q),
    .rom_data (bus.rom_data),
    .sample   (shaped)
  );
  always_comb begin
    acc_d      = bus.tick ? acc_q + bus.freq_word : acc_q;
    v1_d       = bus.tick;
    ph1_d      = bus.tick ? acc_q + bus.phase_offset : ph1_q;
    mode1_d    = bus.tick ? bus.mode : mode1_q;
    idx        = ph1_q[ACC_W-3 -: QADDR_W];
    v2_d       = v1_q;
    ph2_d      = v1_q ? ph1_q : ph2_q;
    mode2_d    = v1_q ? mode1_q : mode2_q;
    neg2_d     = v1_q ? ph1_q[ACC_W-1] : neg2_q;
    rom_addr_d = v1_q ? (ph1_q[ACC_W-2] ? ~idx : idx) : rom_addr_q;
    v3_d       = v2_q;
    ph3_d      = v2_q ? ph2_q : ph3_q;
    mode3_d    = v2_q ? mode2_q : mode3_q;
    neg3_d     = v2_q ? neg2_q : neg3_q;
    valid_d    = v3_q;
    sample_d   = v3_q ? shaped : sample_q;
  end
  always_ff @(posedge CLOCK_50)
    if (!rst_n) begin
      acc_q      <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      rom_addr_q <= '0;
      sample_q   <= MID;
      valid_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      rom_addr_q <= rom_addr_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
    end
  // sideband carries no meaning without its valid bit, so it needs no reset
  always_ff @(posedge CLOCK_50) begin
    ph1_q   <= ph1_d;
    mode1_q <= mode1_d;
    ph2_q   <= ph2_d;
    mode2_q <= mode2_d;
    neg2_q  <= neg2_d;
    ph3_q   <= ph3_d;
    mode3_q <= mode3_d;
    neg3_q  <= neg3_d;
  end
  assign bus.rom_addr     = rom_addr_q;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
endmodule

// File: tb/tb_dds_nco.sv
// tb_dds_nco: directed checks of dds_nco with an identity quarter-wave ROM model
module tb_dds_nco;
  import dds_pkg::*;
  localparam int ACC_W = 16, QADDR_W = 8, DATA_W = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_asrt = 0;
  int n_fail = 0;
  int tq[$], sq[$], vq[$], exp_q[$], aq[$];
  logic [QADDR_W-1:0] addr_log [0:1023];
  dds_nco_if #(.ACC_W(ACC_W), .QADDR_W(QADDR_W), .DATA_W(DATA_W)) bus ();
  dds_nco #(.ACC_W(ACC_W), .QADDR_W(QADDR_W), .DATA_W(DATA_W)) u_dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  // synchronous ROM, 1-cycle latency, rom[a] = a
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.rom_data <= {1'b0, bus.rom_addr};
  end
  always @(negedge clk) begin
    addr_log[cyc[9:0]] = bus.rom_addr;
    if (bus.sample_valid) begin
      sq.push_back(int'(bus.sample_out));
      vq.push_back(cyc);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tq.delete();
    sq.delete();
    vq.delete();
  endtask
  task automatic tick1(input mode_e m, input logic [ACC_W-1:0] f, input logic [ACC_W-1:0] o);
    bus.mode = m;
    bus.freq_word = f;
    bus.phase_offset = o;
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    tq.push_back(cyc);
  endtask
  task automatic drain(input string tag);
    repeat (NCO_LAT + 2) @(posedge clk);
    #1;
    chk({tag, " count"}, sq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sq.size() && i < tq.size(); i++) begin
      chk($sformatf("%s sample[%0d]", tag, i), sq[i], exp_q[i]);
      chk($sformatf("%s latency[%0d]", tag, i), vq[i] - tq[i], NCO_LAT);
    end
  endtask
  initial begin
    bus.tick = 1'b0;
    bus.freq_word = '0;
    bus.phase_offset = '0;
    bus.mode = MODE_SINE;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst sample_out", bus.sample_out, MIDSCALE);
      chk("rst sample_valid", bus.sample_valid, 0);
      chk("rst rom_addr", bus.rom_addr, 0);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle sample_out", bus.sample_out, MIDSCALE);
    chk("idle sample_valid", bus.sample_valid, 0);
    chk("idle rom_addr", bus.rom_addr, 0);
    do_reset();
    repeat (4) tick1(MODE_SINE, 16'h4000, 16'h0000);
    bus.tick = 1'b0;
    exp_q = '{512, 767, 511, 256};
    drain("sine");
    aq = '{0, 255, 0, 255};
    for (int i = 0; i < 4; i++) chk($sformatf("sine rom_addr[%0d]", i), addr_log[tq[i] + 1], aq[i]);
    do_reset();
    repeat (4) tick1(MODE_SAW, 16'h4000, 16'h0000);
    bus.tick = 1'b0;
    exp_q = '{0, 256, 512, 768};
    drain("saw");
    do_reset();
    repeat (4) tick1(MODE_SQUARE, 16'h4000, 16'h0000);
    bus.tick = 1'b0;
    exp_q = '{1023, 1023, 0, 0};
    drain("square");
    do_reset();
    repeat (4) tick1(MODE_TRI, 16'h4000, 16'h0000);
    bus.tick = 1'b0;
    exp_q = '{0, 512, 1023, 511};
    drain("tri");
    do_reset();
    repeat (5) tick1(MODE_SAW, 16'hFFC0, 16'h0000);
    bus.tick = 1'b0;
    exp_q = '{0, 1023, 1022, 1021, 1020};
    drain("wrap");
    if (vq.size() == 5) chk("wrap consecutive", vq[4] - vq[0], 4);
    else chk("wrap valid cycles", vq.size(), 5);
    do_reset();
    tick1(MODE_SINE, 16'h0040, 16'h0000);
    tick1(MODE_SQUARE, 16'h8000, 16'h0000);
    tick1(MODE_SAW, 16'h0000, 16'h0000);
    bus.tick = 1'b0;
    exp_q = '{512, 1023, 513};
    drain("midflight");
    do_reset();
    tick1(MODE_SAW, 16'h0100, 16'h1234);
    bus.tick = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rstmid no valid", sq.size(), 0);
    chk("rstmid sample_out", bus.sample_out, MIDSCALE);
    tq.delete();
    sq.delete();
    vq.delete();
    tick1(MODE_SAW, 16'h0007, 16'h1000);
    bus.tick = 1'b0;
    exp_q = '{64};
    drain("rstmid after");
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
